// File: rtl/h_bdy_fe_seq.sv
// Command body front-end: takes a header, gathers the key and value beats it needs,
// then holds the assembled command until downstream takes it.
package h_pkg;
  typedef enum logic [1:0] {
    OPCODE_NOP    = 2'd0,
    OPCODE_INSERT = 2'd1,
    OPCODE_FIND   = 2'd2,
    OPCODE_DELETE = 2'd3
  } opcode_t;
endpackage

module h_bdy_fe_seq #(
  parameter int W       = 32,
  parameter int K_BEATS = 2,
  parameter int V_BEATS = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_cmd_vld,
  input  h_pkg::opcode_t         i_cmd_opcode,
  output logic                   o_cmd_rdy,
  input  logic                   i_dat_vld,
  input  logic [W-1:0]           i_dat,
  output logic                   o_dat_rdy,
  output logic                   o_vld,
  input  logic                   i_rdy,
  output h_pkg::opcode_t         o_opcode,
  output logic [K_BEATS*W-1:0]   o_k,
  output logic [V_BEATS*W-1:0]   o_v,
  output logic                   o_has_hash,
  output logic                   o_busy
);
  localparam int MAX_BEATS = (K_BEATS > V_BEATS) ? K_BEATS : V_BEATS;
  localparam int CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(K_BEATS - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_BEATS - 1);

  typedef enum logic [1:0] {IDLE, KEY, VAL, OUT} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  h_pkg::opcode_t       opcode_q, opcode_d;
  logic [K_BEATS*W-1:0] k_q, k_d;
  logic [V_BEATS*W-1:0] v_q, v_d;
  logic                 has_hash_q, has_hash_d;
  logic                 hdr_has_k, hdr_has_v, lat_has_v;

  // Header decode works on the incoming opcode; lat_has_v on the latched one.
  assign hdr_has_k = (i_cmd_opcode == h_pkg::OPCODE_INSERT) || (i_cmd_opcode == h_pkg::OPCODE_FIND);
  assign hdr_has_v = (i_cmd_opcode == h_pkg::OPCODE_INSERT);
  assign lat_has_v = (opcode_q == h_pkg::OPCODE_INSERT);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    opcode_d   = opcode_q;
    k_d        = k_q;
    v_d        = v_q;
    has_hash_d = has_hash_q;
    unique case (state_q)
      IDLE: begin
        if (i_cmd_vld) begin
          opcode_d   = i_cmd_opcode;
          has_hash_d = hdr_has_k;
          k_d        = '0;
          v_d        = '0;
          cnt_d      = '0;
          if (hdr_has_k)      state_d = KEY;
          else if (hdr_has_v) state_d = VAL;
          else                state_d = OUT;
        end
      end
      KEY: begin
        if (i_dat_vld) begin
          for (int i = 0; i < K_BEATS; i++) begin
            if (cnt_q == CNT_W'(i)) k_d[i*W +: W] = i_dat;
          end
          if (cnt_q == K_LAST) begin
            cnt_d   = '0;
            state_d = lat_has_v ? VAL : OUT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      VAL: begin
        if (i_dat_vld) begin
          for (int i = 0; i < V_BEATS; i++) begin
            if (cnt_q == CNT_W'(i)) v_d[i*W +: W] = i_dat;
          end
          if (cnt_q == V_LAST) begin
            cnt_d   = '0;
            state_d = OUT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      OUT: begin
        if (i_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      opcode_q   <= h_pkg::OPCODE_NOP;
      k_q        <= '0;
      v_q        <= '0;
      has_hash_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      opcode_q   <= opcode_d;
      k_q        <= k_d;
      v_q        <= v_d;
      has_hash_q <= has_hash_d;
    end
  end

  assign o_cmd_rdy  = (state_q == IDLE);
  assign o_dat_rdy  = (state_q == KEY) || (state_q == VAL);
  assign o_vld      = (state_q == OUT);
  assign o_busy     = (state_q != IDLE);
  assign o_opcode   = opcode_q;
  assign o_k        = k_q;
  assign o_v        = v_q;
  assign o_has_hash = has_hash_q;

endmodule

// File: doc/h_bdy_fe_seq.md
H_BDY_FE_SEQ -- requirements
Module: h_bdy_fe_seq

Interface
REQ-001 SHALL have parameter W, default 32, data beat width in bits (W >= 1).
REQ-002 SHALL have parameter K_BEATS, default 2, key length in beats (K_BEATS >= 1).
REQ-003 SHALL have parameter V_BEATS, default 2, value length in beats (V_BEATS >= 1).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port i_cmd_vld  input  1  command header valid.
REQ-007 SHALL have port i_cmd_opcode  input  h_pkg::opcode_t  command opcode.
REQ-008 SHALL have port o_cmd_rdy  output  1  header accepted when i_cmd_vld && o_cmd_rdy.
REQ-009 SHALL have port i_dat_vld  input  1  body beat valid.
REQ-010 SHALL have port i_dat  input  W  body beat payload.
REQ-011 SHALL have port o_dat_rdy  output  1  beat accepted when i_dat_vld && o_dat_rdy.
REQ-012 SHALL have port o_vld  output  1  assembled command valid.
REQ-013 SHALL have port i_rdy  input  1  downstream accepts when o_vld && i_rdy.
REQ-014 SHALL have ports o_opcode (opcode_t), o_k (K_BEATS*W), o_v (V_BEATS*W), o_has_hash (1): assembled command fields.
REQ-015 SHALL have port o_busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL decode the latched opcode: has_k = opcode in {OPCODE_INSERT, OPCODE_FIND}; has_v = opcode in {OPCODE_INSERT}; has_hash = opcode in {OPCODE_INSERT, OPCODE_FIND}.
REQ-017 SHALL implement FSM states IDLE, KEY, VAL, OUT.
REQ-018 SHALL drive o_cmd_rdy = 1 only in IDLE; o_dat_rdy = 1 only in KEY or VAL; o_vld = 1 only in OUT.
REQ-019 On header accept in IDLE: SHALL latch opcode, clear o_k and o_v to zero, clear beat counter, and next state = KEY if has_k, else VAL if has_v, else OUT.
REQ-020 In KEY: SHALL write each accepted beat into o_k slice [cnt*W +: W] (beat 0 = LSBs) and increment cnt; on accept with cnt == K_BEATS-1, SHALL clear cnt and go to VAL if has_v, else OUT.
REQ-021 In VAL: SHALL write accepted beats into o_v slice [cnt*W +: W]; on accept with cnt == V_BEATS-1, SHALL clear cnt and go to OUT.
REQ-022 Beat counter width SHALL be max(1, $clog2(max(K_BEATS, V_BEATS))); it SHALL never exceed K_BEATS-1 in KEY or V_BEATS-1 in VAL.
REQ-023 In OUT: SHALL hold o_opcode, o_k, o_v, o_has_hash stable while i_rdy = 0; on i_rdy = 1, SHALL go to IDLE.
REQ-024 A header SHALL NOT be accepted in the cycle OUT completes; earliest next header accept is the cycle after OUT exit (one idle bubble).
REQ-025 i_dat_vld in IDLE or OUT SHALL be ignored (beat not consumed); i_cmd_vld outside IDLE SHALL be ignored.
REQ-026 Opcodes outside {INSERT, FIND} SHALL pass IDLE -> OUT with o_k = 0, o_v = 0, o_has_hash = 0.
REQ-027 Minimum latency header-accept to o_vld SHALL be 1 + K_BEATS (FIND), 1 + K_BEATS + V_BEATS (INSERT), 1 (other), in cycles with no stalls.
REQ-028 Stall cycles (i_dat_vld = 0) SHALL not change state, cnt or captured data.

Reset
REQ-029 While rst_n = 0 at a rising edge: state = IDLE, cnt = 0, o_k = 0, o_v = 0, o_opcode = 0, o_has_hash = 0.
REQ-030 After reset: o_vld = 0, o_dat_rdy = 0, o_busy = 0, o_cmd_rdy = 1 (combinational from state).
REQ-031 Reset asserted mid-command (KEY, VAL or OUT) SHALL abandon the command; no o_vld for it after reset release.

Verification
REQ-032 W=8,K=2,V=2: INSERT header, beats 0x11,0x22,0x33,0x44 back-to-back, i_rdy=1 -> o_vld 5 cycles after header accept, o_k=0x2211, o_v=0x4433, o_has_hash=1.
REQ-033 FIND header, beats 0xAA,0xBB -> o_k=0xBBAA, o_v=0x0000, o_has_hash=1, o_vld 3 cycles after accept; VAL never entered.
REQ-034 INSERT with i_dat_vld gapped every other cycle and i_rdy=0 for 4 cycles in OUT -> same fields as REQ-032, outputs stable across stall, exactly one o_vld&&i_rdy handshake.
REQ-035 Unknown opcode header -> o_vld next cycle, o_k=0, o_v=0, o_has_hash=0, no beats consumed while i_dat_vld=1.
REQ-036 rst_n=0 for 1 cycle after second key beat of INSERT -> state IDLE, o_busy=0, o_cmd_rdy=1; new FIND completes with fresh data only.
REQ-037 Parameter sweep K_BEATS=1,V_BEATS=1 and K_BEATS=4,V_BEATS=3 with W=16 -> counters wrap correctly, slice placement LSB-first.
